// File: rtl/seg_digit_driver.sv
// rtl/seg_digit_driver.sv - one 7-segment digit of a multiplexed hex display with
// frame-synchronous commit of a double-buffered 16-bit value, blanking and blink.
module seg_digit_driver #(
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_BITS   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  SEL,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blink_en,
    output logic [6:0]  SEG,
    output logic        pending
);

    localparam logic [3:0]            BLANK_LOAD = 4'(BLANK_CYCLES);
    localparam logic [BLINK_BITS-1:0] BLINK_ONE  = {{(BLINK_BITS-1){1'b0}}, 1'b1};

    logic [15:0]           shadow;
    logic [15:0]           active;
    logic [1:0]            sel_q;
    logic [3:0]            blank_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;

    logic                  frame_edge;
    logic [15:0]           active_nx;
    logic [3:0]            blank_nx;
    logic [BLINK_BITS-1:0] blink_nx;
    logic [3:0]            nibble;
    logic                  blink_off;
    logic [6:0]            seg_nx;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // SEG is built from next-state values so the digit shown in a frame always
    // comes from the value committed at that frame's boundary, never the old one.
    always_comb begin
        frame_edge = (sel_q == 2'b11) && (SEL == 2'b00);
        active_nx  = (frame_edge && pending) ? shadow : active;
        if (SEL != sel_q)
            blank_nx = BLANK_LOAD;
        else if (blank_cnt != 4'd0)
            blank_nx = blank_cnt - 4'd1;
        else
            blank_nx = 4'd0;
        blink_nx = blink_cnt + BLINK_ONE;
        case (SEL)
            2'b00:   nibble = active_nx[15:12];
            2'b01:   nibble = active_nx[11:8];
            2'b10:   nibble = active_nx[7:4];
            default: nibble = active_nx[3:0];
        endcase
        blink_off = (blink_en || (&active_nx[14:10])) && blink_nx[BLINK_BITS-1];
        seg_nx    = ((blank_nx != 4'd0) || blink_off) ? 7'b1111111 : hex_seg(nibble);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            sel_q     <= 2'b00;
            blank_cnt <= '0;
            blink_cnt <= '0;
            SEG       <= 7'b1111111;
        end else begin
            sel_q     <= SEL;
            blank_cnt <= blank_nx;
            blink_cnt <= blink_nx;
            active    <= active_nx;
            SEG       <= seg_nx;
            if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_digit_driver.sv
// tb/tb_seg_digit_driver.sv - self-checking bench for seg_digit_driver with a
// cycle-level reference model; a BLANK_CYCLES=0 instance shares all inputs.
module tb_seg_digit_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  SEL = 2'b00;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        blink_en = 1'b0;
    logic [6:0]  seg, seg0;
    logic        pend, pend0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_shadow, m_active;
    logic        m_pending;
    logic [1:0]  m_prev;
    int          m_since, m_cycle;
    logic [6:0]  m_seg, m_seg0;

    always #5 clock = ~clock;

    seg_digit_driver u_dut (
        .clock(clock), .reset(reset), .SEL(SEL), .load(load), .data_in(data_in),
        .blink_en(blink_en), .SEG(seg), .pending(pend)
    );

    seg_digit_driver #(.BLANK_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .SEL(SEL), .load(load), .data_in(data_in),
        .blink_en(blink_en), .SEG(seg0), .pending(pend0)
    );

    function automatic logic [6:0] hex_glyph(input int n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic model_reset();
        m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
        m_prev = 2'b00; m_since = 1000; m_cycle = 0;
        m_seg = 7'h7F; m_seg0 = 7'h7F;
    endtask

    // One rising edge of the display, described by elapsed-cycle arithmetic.
    task automatic model_step(input logic [1:0] s, input logic l, input logic [15:0] d, input logic b);
        logic boundary, off, blinking;
        int digit;
        boundary = (m_prev == 2'b11) && (s == 2'b00);
        if (boundary && m_pending) m_active = m_shadow;
        if (l) begin
            m_shadow = d; m_pending = 1'b1;
        end else if (boundary) begin
            m_pending = 1'b0;
        end
        m_since  = (s != m_prev) ? 0 : ((m_since < 1000) ? m_since + 1 : 1000);
        m_cycle  = m_cycle + 1;
        off      = (m_cycle % 16) >= 8;
        blinking = b || (m_active[14:10] == 5'h1F);
        digit    = (int'(m_active) >> (4 * (3 - int'(s)))) % 16;
        m_seg0   = (blinking && off) ? 7'h7F : hex_glyph(digit);
        m_seg    = (m_since < 2) ? 7'h7F : m_seg0;
        m_prev   = s;
    endtask

    task automatic tick(input logic [1:0] s, input logic l, input logic [15:0] d, input logic b);
        @(negedge clock);
        SEL = s; load = l; data_in = d; blink_en = b;
        @(posedge clock);
        model_step(s, l, d, b);
        #1;
    endtask

    // Scans SEL 00..11 holding each for 4 cycles; up to two loads at cycle indices la/lb.
    task automatic run_frame(input int la, input logic [15:0] va, input int lb, input logic [15:0] vb,
                             input logic ben, output logic [3:0][6:0] shown, output logic [3:0][6:0] first0);
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 4; j++) begin
                int k;
                k = s * 4 + j;
                tick(2'(s), (k == la) || (k == lb), (k == lb) ? vb : va, ben);
                n_checks += 4;
                if (seg !== m_seg) begin
                    n_errors++; $display("FAIL seg k=%0d got %h exp %h", k, seg, m_seg);
                end
                if (seg0 !== m_seg0) begin
                    n_errors++; $display("FAIL seg_noblank k=%0d got %h exp %h", k, seg0, m_seg0);
                end
                if (pend !== m_pending) begin
                    n_errors++; $display("FAIL pending k=%0d got %b exp %b", k, pend, m_pending);
                end
                if (pend0 !== m_pending) begin
                    n_errors++; $display("FAIL pending_noblank k=%0d got %b exp %b", k, pend0, m_pending);
                end
                if (j == 3) shown[s] = seg;
                if (j == 0) first0[s] = seg0;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        n_checks += 4;
        if (seg !== 7'h7F) begin n_errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
        if (pend !== 1'b0) begin n_errors++; $display("FAIL reset_pending got %b exp 0", pend); end
        if (seg0 !== 7'h7F) begin n_errors++; $display("FAIL reset_seg0 got %h exp 7f", seg0); end
        if (pend0 !== 1'b0) begin n_errors++; $display("FAIL reset_pending0 got %b exp 0", pend0); end
        @(posedge clock); #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_commit();
        logic [3:0][6:0] sh, f0;
        run_frame(6, 16'h3C00, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (pend !== 1'b1) begin n_errors++; $display("FAIL basic_pending_set got %b exp 1", pend); end
        if (sh !== {4{7'h40}}) begin n_errors++; $display("FAIL basic_old_frame got %h exp all 40", sh); end
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (pend !== 1'b0) begin n_errors++; $display("FAIL basic_pending_clr got %b exp 0", pend); end
        if (sh !== {7'h40, 7'h40, 7'h46, 7'h30}) begin
            n_errors++; $display("FAIL basic_digits got %h exp 3,C,0,0", sh);
        end
    endtask

    task automatic test_last_load_wins();
        logic [3:0][6:0] sh, f0;
        run_frame(2, 16'h1234, 9, 16'hABCD, 1'b0, sh, f0);
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        n_checks++;
        if (sh !== {7'h21, 7'h46, 7'h03, 7'h08}) begin
            n_errors++; $display("FAIL last_load_wins got %h exp A,b,C,d", sh);
        end
    endtask

    task automatic test_coincident();
        logic [3:0][6:0] sh, f0;
        run_frame(5, 16'h1111, -1, 16'h0, 1'b0, sh, f0);
        run_frame(0, 16'h2222, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (pend !== 1'b1) begin n_errors++; $display("FAIL coincident_pending got %b exp 1", pend); end
        if (sh !== {4{7'h79}}) begin n_errors++; $display("FAIL coincident_old got %h exp all 1", sh); end
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (sh !== {4{7'h24}}) begin n_errors++; $display("FAIL coincident_new got %h exp all 2", sh); end
        if (pend !== 1'b0) begin n_errors++; $display("FAIL coincident_clr got %b exp 0", pend); end
    endtask

    task automatic test_blank_zero();
        logic [3:0][6:0] sh, f0;
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (f0[3:1] !== {3{7'h24}}) begin
            n_errors++; $display("FAIL blank_zero_first got %h exp no blank 24", f0[3:1]);
        end
        if (sh !== {4{7'h24}}) begin n_errors++; $display("FAIL blank_zero_ref got %h exp all 2", sh); end
    endtask

    task automatic test_special();
        logic [3:0][6:0] sh, f0;
        int offs;
        run_frame(5, 16'h7C00, -1, 16'h0, 1'b0, sh, f0);
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        offs = 0;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
            for (int i = 0; i < 4; i++) if (sh[i] === 7'h7F) offs++;
        end
        n_checks++;
        if (offs == 0) begin n_errors++; $display("FAIL special_blink got %0d off samples exp >0", offs); end
        run_frame(5, 16'h3C00, -1, 16'h0, 1'b0, sh, f0);
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        offs = 0;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
            for (int i = 0; i < 4; i++) if (sh[i] === 7'h7F) offs++;
        end
        n_checks++;
        if (offs != 0) begin n_errors++; $display("FAIL normal_no_blink got %0d off samples exp 0", offs); end
        offs = 0;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, 16'h0, -1, 16'h0, 1'b1, sh, f0);
            for (int i = 0; i < 4; i++) if (sh[i] === 7'h7F) offs++;
        end
        n_checks++;
        if (offs == 0) begin n_errors++; $display("FAIL blink_en got %0d off samples exp >0", offs); end
    endtask

    task automatic test_reset_mid();
        logic [3:0][6:0] sh, f0;
        run_frame(5, 16'h4500, -1, 16'h0, 1'b0, sh, f0);
        run_frame(5, 16'h9999, -1, 16'h0, 1'b0, sh, f0);
        #1 reset = 1'b0;
        #1;
        n_checks += 3;
        if (seg !== 7'h7F) begin n_errors++; $display("FAIL midreset_seg got %h exp 7f", seg); end
        if (pend !== 1'b0) begin n_errors++; $display("FAIL midreset_pending got %b exp 0", pend); end
        if (seg0 !== 7'h7F) begin n_errors++; $display("FAIL midreset_seg0 got %h exp 7f", seg0); end
        @(negedge clock);
        SEL = 2'b00; load = 1'b0;
        @(posedge clock); #2 reset = 1'b1;
        model_reset();
        run_frame(0, 16'h5678, -1, 16'h0, 1'b0, sh, f0);
        n_checks += 2;
        if (sh !== {4{7'h40}}) begin n_errors++; $display("FAIL after_reset_zero got %h exp all 40", sh); end
        if (pend !== 1'b1) begin n_errors++; $display("FAIL first_edge_load got %b exp 1", pend); end
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0, sh, f0);
        n_checks++;
        if (sh !== {7'h00, 7'h78, 7'h02, 7'h12}) begin
            n_errors++; $display("FAIL after_reset_value got %h exp 5,6,7,8", sh);
        end
    endtask

    task automatic test_random();
        logic [1:0]  s;
        logic        b;
        logic [15:0] d;
        s = 2'b00; b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) s = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) b = ~b;
            d = 16'($urandom);
            if ($urandom_range(3) == 0) d[14:10] = 5'h1F;
            tick(s, $urandom_range(7) == 0, d, b);
            n_checks += 3;
            if (seg !== m_seg) begin n_errors++; $display("FAIL rand_seg i=%0d got %h exp %h", i, seg, m_seg); end
            if (seg0 !== m_seg0) begin n_errors++; $display("FAIL rand_seg0 i=%0d got %h exp %h", i, seg0, m_seg0); end
            if (pend !== m_pending) begin n_errors++; $display("FAIL rand_pending i=%0d got %b exp %b", i, pend, m_pending); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_last_load_wins();
        test_coincident();
        test_blank_zero();
        test_special();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_digit_driver.md
SEG_DIGIT_DRIVER -- requirements
Module: seg_digit_driver

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- BLANK_CYCLES, 2, segment-off cycles after each SEL change (range 0..15).
- BLINK_BITS, 4, blink counter width; blink period is 2^BLINK_BITS cycles.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- SEL  input  2  digit select from the display scan FSM; changes on the falling clock edge and is stable at the rising edge.
- load  input  1  one-cycle strobe; capture data_in.
- data_in  input  16  half-precision adder result to display.
- blink_en  input  1  force blinking of all digits.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- pending  output  1  a captured value is waiting to be committed, registered.

Function
REQ-003 On a rising edge with load=1, the block SHALL capture data_in into the shadow register and set pending=1.
REQ-004 A load while pending=1 SHALL overwrite shadow; the last load wins, and earlier uncommitted values SHALL be discarded.
REQ-005 A frame boundary SHALL be defined as sel_q=2'b11 and SEL=2'b00 at a rising edge, where sel_q is SEL registered on the previous rising edge.
REQ-006 At a frame boundary with pending=1, the block SHALL copy shadow into the active register and clear pending on that edge.
REQ-007 A load coincident with a frame boundary SHALL commit the old shadow to active, capture the new data_in into shadow, and leave pending=1.
REQ-008 Without a frame boundary, the active register SHALL NOT change, so no frame is ever a mix of two values.
REQ-009 The block SHALL select the displayed nibble from active as follows.
- SEL=00 selects active[15:12].
- SEL=01 selects active[11:8].
- SEL=10 selects active[7:4].
- SEL=11 selects active[3:0].
REQ-010 The block SHALL decode the nibble to hex glyphs 0-9 and A,b,C,d,E,F. Examples (active-low): 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-011 When SEL != sel_q at a rising edge, the block SHALL load the blank counter with BLANK_CYCLES; otherwise a nonzero blank counter SHALL decrement by 1 per cycle.
REQ-012 SEG SHALL be 7'b1111111 for every cycle in which the blank counter is nonzero.
REQ-013 With BLANK_CYCLES=0, SEG SHALL update with no blanking.
REQ-014 The blink counter SHALL be free-running, BLINK_BITS wide, and wrap modulo 2^BLINK_BITS.
REQ-015 The blink phase SHALL be off when the counter MSB is 1.
REQ-016 Blinking SHALL be enabled when blink_en=1 or active[14:10]=5'b11111 (infinity or NaN result).
REQ-017 During the off blink phase with blinking enabled, SEG SHALL be 7'b1111111.
REQ-018 SEG SHALL be registered, reflecting SEL, the active register and the blanking/blink state one rising edge after they are sampled.
REQ-019 Blanking and blinking SHALL only force segments off; neither SHALL alter active, shadow or pending.

Reset
REQ-020 When reset=0, the block SHALL immediately and asynchronously force shadow=0, active=0, pending=0, sel_q=2'b00, blank counter=0, blink counter=0 and SEG=7'b1111111.
REQ-021 Reset asserted mid-frame or while pending=1 SHALL discard the uncommitted value; after release, the display SHALL show 0000 until the next load and frame boundary.
REQ-022 After reset is released, the first rising edge SHALL resume normal operation; a load on that edge SHALL be captured.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, stimulus -> required response.
- Basic commit: load data_in=16'h3C00 mid-frame -> pending=1; active stays 0000 until the 11->00 transition, then pending=0. The next frame shows SEG=3, C, 0, 0 for SEL=00..11, each preceded by 2 blank cycles.
- Last-load-wins: load 16'h1234 then 16'hABCD before the frame boundary -> the display shows A, b, C, d; 1234 is never shown.
- Coincident load and boundary: shadow=16'h1111 pending, load 16'h2222 on the 11->00 edge -> active=16'h1111 and pending=1; 16'h2222 is shown one frame later.
- Special value: commit 16'h7C00 with blink_en=0 -> SEG is all-off whenever the blink MSB=1 (cycles 8-15 of each 16). Commit 16'h3C00 -> no blink. blink_en=1 with 16'h3C00 -> blinks.
- Reset mid-operation: pending=1 with active=16'h4500, assert reset between clock edges -> SEG=7'b1111111 and pending=0 without waiting for a clock edge. After release the display shows 0000.
- BLANK_CYCLES=0 build: SEL steps 00->01 -> SEG shows the new digit on the next rising edge with no all-off cycle.
